input_sync_debounce: RTL and testbench

- Upstream conditioning stage for the event detector.
- Takes a raw, asynchronous, possibly bouncy single-bit input and passes it through a multi-flop synchronizer.
- Filters the synchronized level so it only changes after it has held steady for a programmable number of clock cycles.
- Drives the clean, clk-domain level that the event detector consumes on its i_Data input.

---
 rtl/input_sync_debounce.sv | 82 ++++++++
 tb/tb_input_sync_debounce.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/input_sync_debounce.sv
// rtl/input_sync_debounce.sv - synchronizer plus stability-qualified debounce for one async input
module input_sync_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = 8,
    parameter logic INIT_LEVEL      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_Data,
    output logic o_Data,
    output logic o_Busy
);

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_CHECK  = 2'd1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_Data};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A single-cycle qualification skips CHECK entirely and toggles straight from STABLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_STABLE;
            cnt    <= '0;
            o_Data <= INIT_LEVEL;
            o_Busy <= 1'b0;
        end else begin
            case (state)
                ST_STABLE: begin
                    cnt    <= '0;
                    o_Busy <= 1'b0;
                    if (sync != o_Data) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            o_Data <= ~o_Data;
                        end else begin
                            state  <= ST_CHECK;
                            cnt    <= CNT_W'(1);
                            o_Busy <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (sync == o_Data) begin
                        state  <= ST_STABLE;
                        cnt    <= '0;
                        o_Busy <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= ST_STABLE;
                        cnt    <= '0;
                        o_Busy <= 1'b0;
                        o_Data <= ~o_Data;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_STABLE;
                    cnt    <= '0;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_sync_debounce.sv
// tb/tb_input_sync_debounce.sv - scoreboard bench for input_sync_debounce
module tb_input_sync_debounce;

    logic clk;
    logic reset;
    logic i_Data;
    logic o_Data;
    logic o_Busy;
    logic din2;
    logic c_Data;
    logic c_Busy;

    int vectors;
    int miscompares;
    logic [1:0] exp_q[$];
    logic [1:0] got;

    input_sync_debounce dut (
        .clk    (clk),
        .reset  (reset),
        .i_Data (i_Data),
        .o_Data (o_Data),
        .o_Busy (o_Busy)
    );

    input_sync_debounce #(
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1),
        .CNT_W           (8),
        .INIT_LEVEL      (1'b1)
    ) dut_corner (
        .clk    (clk),
        .reset  (reset),
        .i_Data (din2),
        .o_Data (c_Data),
        .o_Busy (c_Busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the next input at the falling edge and queue {busy,data} expected after the next rising edge.
    task automatic drive_push(input logic d, input logic eb, input logic ed);
        @(negedge clk);
        i_Data = d;
        exp_q.push_back({eb, ed});
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        exp_q.push_back(2'b00);
        got = exp_q.pop_front();
        vectors++;
        if ({o_Busy, o_Data} !== got) begin
            miscompares++;
            $display("FAIL reset_async main busy,data=%b expected %b", {o_Busy, o_Data}, got);
        end
        exp_q.push_back(2'b01);
        got = exp_q.pop_front();
        vectors++;
        if ({c_Busy, c_Data} !== got) begin
            miscompares++;
            $display("FAIL reset_init_level corner busy,data=%b expected %b", {c_Busy, c_Data}, got);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(2'b00);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            vectors++;
            if ({o_Busy, o_Data} !== got) begin
                miscompares++;
                $display("FAIL reset_held cycle %0d busy,data=%b expected %b", i, {o_Busy, o_Data}, got);
            end
        end
        @(negedge clk);
        i_Data = 1'b0;
        reset  = 1'b0;
    endtask

    task automatic test_clean_rise();
        logic [11:0] din_p, busy_p, data_p;
        din_p  = 12'b0000_0011_1111;
        busy_p = 12'b0111_0001_1100;
        data_p = 12'b0111_1110_0000;
        for (int i = 0; i < 12; i++) begin
            drive_push(din_p[i], busy_p[i], data_p[i]);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            vectors++;
            if ({o_Busy, o_Data} !== got) begin
                miscompares++;
                $display("FAIL clean_step E%0d busy,data=%b expected %b", i + 1, {o_Busy, o_Data}, got);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] din_p, busy_p;
        din_p  = 8'b0000_0011;
        busy_p = 8'b0000_1100;
        for (int i = 0; i < 8; i++) begin
            drive_push(din_p[i], busy_p[i], 1'b0);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            vectors++;
            if ({o_Busy, o_Data} !== got) begin
                miscompares++;
                $display("FAIL glitch E%0d busy,data=%b expected %b", i + 1, {o_Busy, o_Data}, got);
            end
        end
    endtask

    task automatic test_reset_mid_check();
        logic [11:0] din_p, busy_p, data_p;
        for (int i = 0; i < 4; i++) begin
            drive_push(1'b1, (i >= 2), 1'b0);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            vectors++;
            if ({o_Busy, o_Data} !== got) begin
                miscompares++;
                $display("FAIL midreset_qualify E%0d busy,data=%b expected %b", i + 1, {o_Busy, o_Data}, got);
            end
        end
        #1 reset = 1'b1;
        #1;
        exp_q.push_back(2'b00);
        got = exp_q.pop_front();
        vectors++;
        if ({o_Busy, o_Data} !== got) begin
            miscompares++;
            $display("FAIL midreset_abort busy,data=%b expected %b", {o_Busy, o_Data}, got);
        end
        din_p  = 12'b0000_0011_1111;
        busy_p = 12'b0111_0001_1100;
        data_p = 12'b0111_1110_0000;
        for (int i = 0; i < 12; i++) begin
            drive_push(din_p[i], busy_p[i], data_p[i]);
            if (i == 0) reset = 1'b0;
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            vectors++;
            if ({o_Busy, o_Data} !== got) begin
                miscompares++;
                $display("FAIL midreset_requalify E%0d busy,data=%b expected %b", i + 1, {o_Busy, o_Data}, got);
            end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] din_p, busy_p, data_p;
        din_p  = 12'b1111_1111_0101;
        busy_p = 12'b0001_1101_0100;
        data_p = 12'b1110_0000_0000;
        for (int i = 0; i < 12; i++) begin
            drive_push(din_p[i], busy_p[i], data_p[i]);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            vectors++;
            if ({o_Busy, o_Data} !== got) begin
                miscompares++;
                $display("FAIL bounce E%0d busy,data=%b expected %b", i + 1, {o_Busy, o_Data}, got);
            end
        end
    endtask

    task automatic test_corner_params();
        logic [7:0] din_p, data_p;
        din_p  = 8'b1111_0000;
        data_p = 8'b1000_0111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            din2 = din_p[i];
            exp_q.push_back({1'b0, data_p[i]});
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            vectors++;
            if ({c_Busy, c_Data} !== got) begin
                miscompares++;
                $display("FAIL corner_step E%0d busy,data=%b expected %b", i + 1, {c_Busy, c_Data}, got);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        i_Data      = 1'b1;
        din2        = 1'b1;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_reset_mid_check();
        test_bounce();
        test_corner_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
